// File: rtl/collision_scheduler.sv
// collision_scheduler: per-frame sequencer for one shared do_collision core.
// Walks the obstacle ROM, launches the core once per obstacle, chains the
// resolved position/velocity of each hit into the next launch, and sums the
// per-obstacle accelerations with signed saturation.
// Optional feature macro: WATCHDOG_EN (per-launch core timeout, sticky timeout_out).
module collision_scheduler #(
  parameter int NUM_OBSTACLES     = 4,
  parameter int NUM_VERTICES      = 5,
  parameter int POSITION_SIZE     = 8,
  parameter int VELOCITY_SIZE     = 8,
  parameter int ACCELERATION_SIZE = 8,
  parameter int TIMEOUT_CYCLES    = 255,
  localparam int ADDR_W = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1,
  localparam int HIT_W  = $clog2(NUM_OBSTACLES + 1)
) (
  input  logic                                               clk_in,
  input  logic                                               rst_in,
  input  logic                                               begin_in,
  input  logic [POSITION_SIZE-1:0]                           pos_x_in,
  input  logic [POSITION_SIZE-1:0]                           pos_y_in,
  input  logic [POSITION_SIZE-1:0]                           dx_in,
  input  logic [POSITION_SIZE-1:0]                           dy_in,
  input  logic [VELOCITY_SIZE-1:0]                           vel_x_in,
  input  logic [VELOCITY_SIZE-1:0]                           vel_y_in,
  output logic [ADDR_W-1:0]                                  obs_addr_out,
  input  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]    obs_vert_in,
  input  logic [POSITION_SIZE-1:0]                           obs_nverts_in,
  output logic                                               core_begin_out,
  output logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]    core_obstacle_out,
  output logic [POSITION_SIZE-1:0]                           core_num_vertices_out,
  output logic [POSITION_SIZE-1:0]                           core_pos_x_out,
  output logic [POSITION_SIZE-1:0]                           core_pos_y_out,
  output logic [VELOCITY_SIZE-1:0]                           core_vel_x_out,
  output logic [VELOCITY_SIZE-1:0]                           core_vel_y_out,
  output logic [POSITION_SIZE-1:0]                           core_d_x_out,
  output logic [POSITION_SIZE-1:0]                           core_d_y_out,
  input  logic                                               core_result_in,
  input  logic                                               core_was_collision_in,
  input  logic [POSITION_SIZE-1:0]                           core_x_new_in,
  input  logic [POSITION_SIZE-1:0]                           core_y_new_in,
  input  logic [VELOCITY_SIZE-1:0]                           core_vel_x_new_in,
  input  logic [VELOCITY_SIZE-1:0]                           core_vel_y_new_in,
  input  logic [POSITION_SIZE-1:0]                           core_x_int_in,
  input  logic [POSITION_SIZE-1:0]                           core_y_int_in,
  input  logic [ACCELERATION_SIZE-1:0]                       core_acc_x_in,
  input  logic [ACCELERATION_SIZE-1:0]                       core_acc_y_in,
  output logic                                               busy_out,
  output logic                                               done_out,
  output logic [POSITION_SIZE-1:0]                           x_out,
  output logic [POSITION_SIZE-1:0]                           y_out,
  output logic [VELOCITY_SIZE-1:0]                           vel_x_out,
  output logic [VELOCITY_SIZE-1:0]                           vel_y_out,
  output logic [ACCELERATION_SIZE-1:0]                       acc_x_out,
  output logic [ACCELERATION_SIZE-1:0]                       acc_y_out,
  output logic [HIT_W-1:0]                                   hit_count_out,
  output logic                                               timeout_out
);

  localparam int A = ACCELERATION_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ROMWAIT, S_LAUNCH, S_WAIT_CORE, S_ACCUM, S_DONE
  } state_t;

  // Signed add clamped to the most negative / most positive acceleration.
  function automatic logic [A-1:0] sat_add(input logic [A-1:0] a, input logic [A-1:0] b);
    logic [A:0] s;
    s = {a[A-1], a} + {b[A-1], b};
    if (s[A] != s[A-1]) begin
      sat_add = s[A] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
    end else begin
      sat_add = s[A-1:0];
    end
  endfunction

  state_t                   state;
  logic [ADDR_W-1:0]        idx;
  logic [POSITION_SIZE-1:0] pos_x, pos_y, d_x, d_y;
  logic [VELOCITY_SIZE-1:0] vel_x, vel_y;
  logic [A-1:0]             acc_x, acc_y;
  logic [HIT_W-1:0]         hit_count;

  // Core results captured on the done pulse, applied in ACCUM.
  logic                     cap_hit;
  logic [POSITION_SIZE-1:0] cap_x_new, cap_y_new, cap_x_int, cap_y_int;
  logic [VELOCITY_SIZE-1:0] cap_vel_x, cap_vel_y;
  logic [A-1:0]             cap_acc_x, cap_acc_y;

  logic nverts_bad;
  assign nverts_bad = (obs_nverts_in < POSITION_SIZE'(3)) ||
                      (obs_nverts_in > POSITION_SIZE'(NUM_VERTICES));

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;
`else
  assign timeout_out = 1'b0;
`endif

  // Frame sequencer: walks obstacles, drives the core and produces registered results.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                 <= S_IDLE;
      idx                   <= '0;
      pos_x <= '0; pos_y <= '0; d_x <= '0; d_y <= '0;
      vel_x <= '0; vel_y <= '0; acc_x <= '0; acc_y <= '0;
      hit_count             <= '0;
      cap_hit <= 1'b0; cap_x_new <= '0; cap_y_new <= '0; cap_x_int <= '0; cap_y_int <= '0;
      cap_vel_x <= '0; cap_vel_y <= '0; cap_acc_x <= '0; cap_acc_y <= '0;
      obs_addr_out          <= '0;
      core_begin_out        <= 1'b0;
      core_obstacle_out     <= '0;
      core_num_vertices_out <= '0;
      core_pos_x_out <= '0; core_pos_y_out <= '0;
      core_vel_x_out <= '0; core_vel_y_out <= '0;
      core_d_x_out   <= '0; core_d_y_out   <= '0;
      busy_out <= 1'b0; done_out <= 1'b0;
      x_out <= '0; y_out <= '0; vel_x_out <= '0; vel_y_out <= '0;
      acc_x_out <= '0; acc_y_out <= '0; hit_count_out <= '0;
`ifdef WATCHDOG_EN
      wdog_cnt    <= '0;
      timeout_out <= 1'b0;
`endif
    end else begin
      core_begin_out <= 1'b0;
      done_out       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (begin_in) begin
            pos_x <= pos_x_in; pos_y <= pos_y_in;
            d_x   <= dx_in;    d_y   <= dy_in;
            vel_x <= vel_x_in; vel_y <= vel_y_in;
            acc_x <= '0; acc_y <= '0;
            hit_count <= '0;
            idx       <= '0;
            busy_out  <= 1'b1;
`ifdef WATCHDOG_EN
            timeout_out <= 1'b0;
`endif
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          obs_addr_out <= idx;
          state        <= S_ROMWAIT;
        end
        S_ROMWAIT: begin
          state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          core_obstacle_out     <= obs_vert_in;
          core_num_vertices_out <= obs_nverts_in;
          core_pos_x_out <= pos_x; core_pos_y_out <= pos_y;
          core_vel_x_out <= vel_x; core_vel_y_out <= vel_y;
          core_d_x_out   <= d_x;   core_d_y_out   <= d_y;
          if (nverts_bad) begin
            // Degenerate or oversized polygon: counted as a miss without using the core.
            cap_hit <= 1'b0;
            state   <= S_ACCUM;
          end else begin
            core_begin_out <= 1'b1;
`ifdef WATCHDOG_EN
            wdog_cnt <= '0;
`endif
            state <= S_WAIT_CORE;
          end
        end
        S_WAIT_CORE: begin
          if (core_result_in) begin
            cap_hit   <= core_was_collision_in;
            cap_x_new <= core_x_new_in;     cap_y_new <= core_y_new_in;
            cap_x_int <= core_x_int_in;     cap_y_int <= core_y_int_in;
            cap_vel_x <= core_vel_x_new_in; cap_vel_y <= core_vel_y_new_in;
            cap_acc_x <= core_acc_x_in;     cap_acc_y <= core_acc_y_in;
            state     <= S_ACCUM;
          end
`ifdef WATCHDOG_EN
          else if (wdog_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            // Core unresponsive: abandon this obstacle as a miss.
            cap_hit     <= 1'b0;
            timeout_out <= 1'b1;
            state       <= S_ACCUM;
          end else begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
          end
`else
          else begin
            state <= S_WAIT_CORE;
          end
`endif
        end
        S_ACCUM: begin
          if (cap_hit) begin
            pos_x <= cap_x_int;             pos_y <= cap_y_int;
            vel_x <= cap_vel_x;             vel_y <= cap_vel_y;
            d_x   <= cap_x_new - cap_x_int; d_y   <= cap_y_new - cap_y_int;
            acc_x <= sat_add(acc_x, cap_acc_x);
            acc_y <= sat_add(acc_y, cap_acc_y);
            hit_count <= hit_count + HIT_W'(1);
          end else begin
            hit_count <= hit_count;
          end
          if (idx == ADDR_W'(NUM_OBSTACLES - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          x_out         <= pos_x + d_x;
          y_out         <= pos_y + d_y;
          vel_x_out     <= vel_x;
          vel_y_out     <= vel_y;
          acc_x_out     <= acc_x;
          acc_y_out     <= acc_y;
          hit_count_out <= hit_count;
          done_out      <= 1'b1;
          busy_out      <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
